// File: rtl/rvh_l1d_ld_resp_buf.sv
// L1D load-response buffer: formats load results at enqueue, holds them in per-source
// FIFOs and drains them through one round-robin, back-pressurable writeback port.
module rvh_l1d_ld_resp_buf #(
  parameter int XLEN           = 64,
  parameter int DATA_W         = 128,
  parameter int OFF_W          = $clog2(DATA_W/8),
  parameter int NUM_SRC        = 2,
  parameter int DEPTH          = 4,
  parameter int ROB_TAG_WIDTH  = 6,
  parameter int PREG_TAG_WIDTH = 7,
  parameter int PTW_ID_WIDTH   = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     flush_i,
  input  logic [NUM_SRC-1:0]                       in_vld_i,
  output logic [NUM_SRC-1:0]                       in_rdy_o,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]           in_data_i,
  input  logic [NUM_SRC-1:0][OFF_W-1:0]            in_offset_i,
  input  logic [NUM_SRC-1:0][1:0]                  in_size_i,
  input  logic [NUM_SRC-1:0]                       in_unsigned_i,
  input  logic [NUM_SRC-1:0]                       in_is_ptw_i,
  input  logic [NUM_SRC-1:0]                       in_stb_byp_vld_i,
  input  logic [NUM_SRC-1:0][XLEN-1:0]             in_stb_byp_data_i,
  input  logic [NUM_SRC-1:0][ROB_TAG_WIDTH-1:0]    in_rob_tag_i,
  input  logic [NUM_SRC-1:0][PREG_TAG_WIDTH-1:0]   in_prd_i,
  output logic                                     l1d_wb_vld_o,
  input  logic                                     l1d_wb_rdy_i,
  output logic [ROB_TAG_WIDTH-1:0]                 l1d_wb_rob_tag_o,
  output logic [PREG_TAG_WIDTH-1:0]                l1d_wb_prd_o,
  output logic [XLEN-1:0]                          l1d_wb_data_o,
  output logic                                     l1d_wb_from_mlfb_o,
  output logic                                     l1d_ptw_walk_vld_o,
  output logic [PTW_ID_WIDTH-1:0]                  l1d_ptw_walk_id_o,
  output logic [XLEN-1:0]                          l1d_ptw_walk_pte_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic                      is_ptw;
    logic [ROB_TAG_WIDTH-1:0]  rob_tag;
    logic [PREG_TAG_WIDTH-1:0] prd;
    logic [XLEN-1:0]           data;
  } entry_t;

  entry_t         mem_q    [NUM_SRC][DEPTH];
  entry_t         mem_d    [NUM_SRC][DEPTH];
  entry_t         new_e    [NUM_SRC];
  entry_t         head_e;
  logic [PW-1:0]  head_q   [NUM_SRC];
  logic [PW-1:0]  tail_q   [NUM_SRC];
  logic [CW-1:0]  cnt_q    [NUM_SRC];
  logic [CW-1:0]  keep_cnt [NUM_SRC];
  logic [NUM_SRC-1:0] enq;
  logic [NUM_SRC-1:0] deq_src;
  logic [SW-1:0]  rr_q, nxt_rr, sel, cand, lock_src_q;
  logic           lock_q, found, deq;

  // PTW entries keep the raw 64 bits; everything else is masked and extended.
  function automatic logic [XLEN-1:0] fmt_load(
    input logic [DATA_W-1:0] data,
    input logic [OFF_W-1:0]  off,
    input logic [1:0]        size,
    input logic              uns,
    input logic              ptw,
    input logic              byp,
    input logic [XLEN-1:0]   byp_data
  );
    logic [DATA_W+XLEN-1:0] wide;
    logic [XLEN-1:0]        raw;
    logic [XLEN-1:0]        res;
    logic                   sx;
    wide = {{XLEN{1'b0}}, data} >> {off, 3'b000};
    raw  = byp ? byp_data : wide[XLEN-1:0];
    sx   = ~uns;
    case (size)
      2'd0:    res = {{(XLEN-8){sx & raw[7]}}, raw[7:0]};
      2'd1:    res = {{(XLEN-16){sx & raw[15]}}, raw[15:0]};
      2'd2:    res = {{(XLEN-32){sx & raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return ptw ? raw : res;
  endfunction

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      in_rdy_o[s]    = (cnt_q[s] != CW'(DEPTH)) & ~flush_i;
      enq[s]         = in_vld_i[s] & in_rdy_o[s];
      new_e[s].is_ptw  = in_is_ptw_i[s];
      new_e[s].rob_tag = in_rob_tag_i[s];
      new_e[s].prd     = in_prd_i[s];
      new_e[s].data    = fmt_load(in_data_i[s], in_offset_i[s], in_size_i[s], in_unsigned_i[s],
                                  in_is_ptw_i[s], in_stb_byp_vld_i[s], in_stb_byp_data_i[s]);
    end
  end

  // Reverse scan so the lowest distance from rr wins.
  always_comb begin
    sel   = lock_src_q;
    found = lock_q;
    cand  = '0;
    if (!lock_q) begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        cand = SW'((int'(rr_q) + i) % NUM_SRC);
        if (cnt_q[cand] != '0) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  always_comb begin
    head_e             = mem_q[sel][head_q[sel]];
    l1d_ptw_walk_vld_o = found & head_e.is_ptw & ~flush_i;
    l1d_wb_vld_o       = found & ~head_e.is_ptw & ~flush_i;
    deq                = l1d_ptw_walk_vld_o | (l1d_wb_vld_o & l1d_wb_rdy_i);
    for (int s = 0; s < NUM_SRC; s++) deq_src[s] = deq & (sel == SW'(s));
    nxt_rr             = (int'(sel) == NUM_SRC - 1) ? '0 : sel + SW'(1);
    l1d_wb_rob_tag_o   = head_e.rob_tag;
    l1d_wb_prd_o       = head_e.prd;
    l1d_wb_data_o      = head_e.data;
    l1d_wb_from_mlfb_o = (int'(sel) == NUM_SRC - 1);
    l1d_ptw_walk_id_o  = head_e.rob_tag[PTW_ID_WIDTH-1:0];
    l1d_ptw_walk_pte_o = head_e.data;
  end

  // Flush compacts surviving PTW entries to slot 0 onward of each queue.
  always_comb begin
    mem_d = mem_q;
    for (int s = 0; s < NUM_SRC; s++) keep_cnt[s] = '0;
    if (flush_i) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ((CW'(i) < cnt_q[s]) && mem_q[s][head_q[s] + PW'(i)].is_ptw) begin
            mem_d[s][keep_cnt[s][PW-1:0]] = mem_q[s][head_q[s] + PW'(i)];
            keep_cnt[s] = keep_cnt[s] + CW'(1);
          end
        end
      end
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (enq[s]) mem_d[s][tail_q[s]] = new_e[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        cnt_q[s]  <= '0;
        head_q[s] <= '0;
        tail_q[s] <= '0;
      end
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= '0;
    end else if (flush_i) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        cnt_q[s]  <= keep_cnt[s];
        head_q[s] <= '0;
        tail_q[s] <= keep_cnt[s][PW-1:0];
      end
      lock_q <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (enq[s])     tail_q[s] <= tail_q[s] + PW'(1);
        if (deq_src[s]) head_q[s] <= head_q[s] + PW'(1);
        cnt_q[s] <= cnt_q[s] + CW'(enq[s]) - CW'(deq_src[s]);
      end
      if (deq) rr_q <= nxt_rr;
      lock_q     <= l1d_wb_vld_o & ~l1d_wb_rdy_i;
      lock_src_q <= sel;
    end
  end

endmodule

// File: tb/tb_rvh_l1d_ld_resp_buf.sv
// Directed bench for rvh_l1d_ld_resp_buf: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_rvh_l1d_ld_resp_buf;
  localparam int NS = 2;
  localparam int DW = 128;
  localparam int XL = 64;
  localparam int OW = 4;
  localparam int RT = 6;
  localparam int PT = 7;
  localparam int PI = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [NS-1:0] in_vld, in_rdy, in_unsigned, in_is_ptw, in_stb_byp_vld;
  logic [NS-1:0][DW-1:0] in_data;
  logic [NS-1:0][OW-1:0] in_offset;
  logic [NS-1:0][1:0] in_size;
  logic [NS-1:0][XL-1:0] in_stb_byp_data;
  logic [NS-1:0][RT-1:0] in_rob_tag;
  logic [NS-1:0][PT-1:0] in_prd;
  logic wb_rdy, l1d_wb_vld, l1d_wb_from_mlfb, ptw_vld;
  logic [RT-1:0] l1d_wb_rob_tag;
  logic [PT-1:0] l1d_wb_prd;
  logic [XL-1:0] l1d_wb_data, ptw_pte;
  logic [PI-1:0] ptw_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvh_l1d_ld_resp_buf #(
    .XLEN(XL), .DATA_W(DW), .OFF_W(OW), .NUM_SRC(NS), .DEPTH(4),
    .ROB_TAG_WIDTH(RT), .PREG_TAG_WIDTH(PT), .PTW_ID_WIDTH(PI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_data_i(in_data), .in_offset_i(in_offset),
    .in_size_i(in_size), .in_unsigned_i(in_unsigned), .in_is_ptw_i(in_is_ptw),
    .in_stb_byp_vld_i(in_stb_byp_vld), .in_stb_byp_data_i(in_stb_byp_data),
    .in_rob_tag_i(in_rob_tag), .in_prd_i(in_prd),
    .l1d_wb_vld_o(l1d_wb_vld), .l1d_wb_rdy_i(wb_rdy), .l1d_wb_rob_tag_o(l1d_wb_rob_tag),
    .l1d_wb_prd_o(l1d_wb_prd), .l1d_wb_data_o(l1d_wb_data), .l1d_wb_from_mlfb_o(l1d_wb_from_mlfb),
    .l1d_ptw_walk_vld_o(ptw_vld), .l1d_ptw_walk_id_o(ptw_id), .l1d_ptw_walk_pte_o(ptw_pte)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Byte-by-byte reference formatting.
  function automatic logic [63:0] model_fmt(input logic [127:0] d, input int off, input int size,
                                            input bit uns, input bit ptw, input bit byp,
                                            input logic [63:0] bd);
    logic [63:0] v;
    int nb;
    v  = '0;
    nb = ptw ? 8 : (1 << size);
    for (int b = 0; b < nb; b++) begin
      if (byp) v[8*b +: 8] = bd[8*b +: 8];
      else if (off + b < 16) v[8*b +: 8] = d[8*(off+b) +: 8];
      else v[8*b +: 8] = 8'h00;
    end
    if (!ptw && !uns && nb < 8 && v[8*nb-1])
      for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  typedef struct {
    logic [63:0] data;
    logic [RT-1:0] tag;
    logic [PT-1:0] prd;
    bit ptw;
  } ent_t;

  ent_t mq [NS][$];
  ent_t tmpq [$];
  ent_t m_head, nw;
  int m_rr, m_lsrc, m_sel;
  bit m_lock, m_found, e_wb, e_ptw;
  logic [NS-1:0] e_rdy, m_enq;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      m_rr = 0; m_lock = 0; m_lsrc = 0;
      chk("m_rst_wb_vld", 64'(l1d_wb_vld), 64'h0);
      chk("m_rst_ptw_vld", 64'(ptw_vld), 64'h0);
      chk("m_rst_in_rdy", 64'(in_rdy), 64'h3);
    end else begin
      m_found = 0; m_sel = 0;
      if (m_lock) begin
        m_found = 1; m_sel = m_lsrc;
      end else begin
        for (int i = 0; i < NS; i++)
          if (!m_found && mq[(m_rr + i) % NS].size() > 0) begin
            m_found = 1; m_sel = (m_rr + i) % NS;
          end
      end
      e_wb = 0; e_ptw = 0;
      if (m_found && !flush) begin
        m_head = mq[m_sel][0];
        if (m_head.ptw) e_ptw = 1; else e_wb = 1;
      end
      for (int s = 0; s < NS; s++) e_rdy[s] = (mq[s].size() < 4) && !flush;
      chk("m_wb_vld", 64'(l1d_wb_vld), 64'(e_wb));
      chk("m_ptw_vld", 64'(ptw_vld), 64'(e_ptw));
      chk("m_in_rdy", 64'(in_rdy), 64'(e_rdy));
      if (e_wb && l1d_wb_vld) begin
        chk("m_wb_data", l1d_wb_data, m_head.data);
        chk("m_wb_tag", 64'(l1d_wb_rob_tag), 64'(m_head.tag));
        chk("m_wb_prd", 64'(l1d_wb_prd), 64'(m_head.prd));
        chk("m_wb_mlfb", 64'(l1d_wb_from_mlfb), 64'(m_sel == NS - 1));
      end
      if (e_ptw && ptw_vld) begin
        chk("m_ptw_pte", ptw_pte, m_head.data);
        chk("m_ptw_id", 64'(ptw_id), 64'(m_head.tag[PI-1:0]));
      end
      if (flush) begin
        for (int s = 0; s < NS; s++) begin
          tmpq.delete();
          for (int j = 0; j < mq[s].size(); j++) if (mq[s][j].ptw) tmpq.push_back(mq[s][j]);
          mq[s] = tmpq;
        end
        m_lock = 0;
      end else begin
        for (int s = 0; s < NS; s++) m_enq[s] = in_vld[s] && e_rdy[s];
        if (e_ptw || (e_wb && wb_rdy)) begin
          void'(mq[m_sel].pop_front());
          m_rr = (m_sel + 1) % NS;
          m_lock = 0;
        end else if (e_wb) begin
          m_lock = 1; m_lsrc = m_sel;
        end
        for (int s = 0; s < NS; s++) if (m_enq[s]) begin
          nw.data = model_fmt(in_data[s], int'(in_offset[s]), int'(in_size[s]), in_unsigned[s],
                              in_is_ptw[s], in_stb_byp_vld[s], in_stb_byp_data[s]);
          nw.tag = in_rob_tag[s];
          nw.prd = in_prd[s];
          nw.ptw = in_is_ptw[s];
          mq[s].push_back(nw);
        end
      end
    end
  end

  logic [63:0] log_data [$];
  logic        log_src  [$];
  always @(negedge clk)
    if (rst_n && l1d_wb_vld && wb_rdy) begin
      log_data.push_back(l1d_wb_data);
      log_src.push_back(l1d_wb_from_mlfb);
    end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic sync(); @(posedge clk); #1; endtask
  task automatic negs(); @(negedge clk); #1; endtask
  task automatic clr();
    in_vld = '0; in_stb_byp_vld = '0; in_is_ptw = '0; in_unsigned = '0;
  endtask
  task automatic put(input int s, input logic [127:0] d, input int off, input int sz, input bit uns,
                     input bit ptw, input bit byp, input logic [63:0] bd,
                     input logic [RT-1:0] tag, input logic [PT-1:0] prd);
    in_vld[s] = 1'b1; in_data[s] = d; in_offset[s] = OW'(off); in_size[s] = 2'(sz);
    in_unsigned[s] = uns; in_is_ptw[s] = ptw; in_stb_byp_vld[s] = byp;
    in_stb_byp_data[s] = bd; in_rob_tag[s] = tag; in_prd[s] = prd;
  endtask
  // Single src0 load, checked the cycle after it is accepted; rdy must be 1.
  task automatic one(input string name, input logic [127:0] d, input int off, input int sz,
                     input bit uns, input bit byp, input logic [63:0] bd, input logic [63:0] exp);
    put(0, d, off, sz, uns, 0, byp, bd, 6'h05, 7'h11);
    sync(); clr();
    negs();
    chk({name, "_vld"}, 64'(l1d_wb_vld), 64'h1);
    chk({name, "_data"}, l1d_wb_data, exp);
    chk({name, "_mlfb"}, 64'(l1d_wb_from_mlfb), 64'h0);
    sync();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_rdy = 1'b1;
    clr();
    in_data = '0; in_offset = '0; in_size = '0; in_stb_byp_data = '0; in_rob_tag = '0; in_prd = '0;
    sync(); sync();
    negs();
    chk("reset_wb_vld", 64'(l1d_wb_vld), 64'h0);
    chk("reset_ptw_vld", 64'(ptw_vld), 64'h0);
    chk("reset_in_rdy", 64'(in_rdy), 64'h3);
    sync(); rst_n = 1'b1;
    sync();

    one("hit_w", 128'h0011223344556677_8899AABBCCDDEEFF, 4, 2, 0, 0, '0, 64'hFFFF_FFFF_8899_AABB);
    one("byp_b_s", 128'h0, 0, 0, 0, 1, 64'h80, 64'hFFFF_FFFF_FFFF_FF80);
    one("byp_b_u", 128'h0, 0, 0, 1, 1, 64'h80, 64'h0000_0000_0000_0080);
    one("edge_dw", 128'hCDAB_1111_2222_3333_4444_5555_6666_7777, 14, 3, 1, 0, '0, 64'h0000_0000_0000_CDAB);
    one("edge_hw_s", 128'hCDAB_1111_2222_3333_4444_5555_6666_7777, 14, 1, 0, 0, '0, 64'hFFFF_FFFF_FFFF_CDAB);

    // back-pressure: five offered, four accepted
    wb_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(0, {64'h0, 64'h1000 + 64'(k)}, 0, 3, 1, 0, 0, '0, RT'(k), PT'(k));
      sync();
      if (k == 3) chk("bp_rdy_full", 64'(in_rdy[0]), 64'h0);
    end
    clr();
    negs();
    chk("bp_head", l1d_wb_data, 64'h1000);
    repeat (4) sync();
    negs();
    chk("bp_stable_vld", 64'(l1d_wb_vld), 64'h1);
    chk("bp_stable_data", l1d_wb_data, 64'h1000);
    sync();
    wb_rdy = 1'b1;
    log_data.delete(); log_src.delete();
    repeat (6) sync();
    chk("bp_drain_cnt", 64'(log_data.size()), 64'h4);
    for (int k = 0; k < 4; k++)
      chk("bp_drain_data", (k < log_data.size()) ? log_data[k] : 64'hBAD, 64'h1000 + 64'(k));

    // PTW response from src1 while writeback is stalled
    wb_rdy = 1'b0;
    put(1, {64'h0, 64'hDEAD_BEEF_CAFE_F00D}, 0, 0, 0, 1, 0, '0, 6'h2E, 7'h00);
    sync(); clr();
    negs();
    chk("ptw_pulse", 64'(ptw_vld), 64'h1);
    chk("ptw_pte", ptw_pte, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ptw_id", 64'(ptw_id), 64'h2);
    chk("ptw_no_wb", 64'(l1d_wb_vld), 64'h0);
    sync(); negs();
    chk("ptw_single", 64'(ptw_vld), 64'h0);
    sync();

    // round robin: three entries per source
    for (int k = 0; k < 3; k++) begin
      put(0, {64'h0, 64'hA0 + 64'(k)}, 0, 3, 1, 0, 0, '0, 6'h0A, 7'h0A);
      put(1, {64'h0, 64'hB0 + 64'(k)}, 0, 3, 1, 0, 0, '0, 6'h0B, 7'h0B);
      sync();
    end
    clr();
    negs();
    chk("rr_first", l1d_wb_data, 64'hA0);
    sync();
    wb_rdy = 1'b1;
    log_data.delete(); log_src.delete();
    repeat (8) sync();
    chk("rr_cnt", 64'(log_data.size()), 64'h6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_src", (k < log_src.size()) ? 64'(log_src[k]) : 64'hBAD, 64'(k % 2));
      chk("rr_data", (k < log_data.size()) ? log_data[k] : 64'hBAD,
          ((k % 2 == 0) ? 64'hA0 : 64'hB0) + 64'(k / 2));
    end

    // flush with normal, PTW, normal queued in src0
    wb_rdy = 1'b0;
    put(0, {64'h0, 64'hC0}, 0, 3, 1, 0, 0, '0, 6'h10, 7'h10); sync();
    put(0, {64'h0, 64'h5555_AAAA_5555_AAAA}, 0, 0, 0, 1, 0, '0, 6'h03, 7'h00); sync();
    put(0, {64'h0, 64'hC1}, 0, 3, 1, 0, 0, '0, 6'h11, 7'h11); sync();
    clr(); flush = 1'b1;
    negs();
    chk("fl_wb", 64'(l1d_wb_vld), 64'h0);
    chk("fl_ptw", 64'(ptw_vld), 64'h0);
    chk("fl_rdy", 64'(in_rdy), 64'h0);
    sync(); flush = 1'b0;
    negs();
    chk("fl_ptw_pulse", 64'(ptw_vld), 64'h1);
    chk("fl_pte", ptw_pte, 64'h5555_AAAA_5555_AAAA);
    chk("fl_id", 64'(ptw_id), 64'h3);
    chk("fl_no_wb", 64'(l1d_wb_vld), 64'h0);
    sync(); negs();
    chk("fl_empty_wb", 64'(l1d_wb_vld), 64'h0);
    chk("fl_empty_ptw", 64'(ptw_vld), 64'h0);
    chk("fl_empty_rdy", 64'(in_rdy), 64'h3);
    sync();

    // asynchronous reset with entries buffered
    put(0, {64'h0, 64'hE0}, 0, 3, 1, 0, 0, '0, 6'h20, 7'h20);
    put(1, {64'h0, 64'hE1}, 0, 3, 1, 0, 0, '0, 6'h21, 7'h21);
    sync(); clr();
    negs();
    chk("pre_rst_data", l1d_wb_data, 64'hE1);
    sync();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wb", 64'(l1d_wb_vld), 64'h0);
    chk("mid_rst_ptw", 64'(ptw_vld), 64'h0);
    chk("mid_rst_rdy", 64'(in_rdy), 64'h3);
    sync();
    rst_n = 1'b1; wb_rdy = 1'b1;
    repeat (3) sync();
    negs();
    chk("post_rst_wb", 64'(l1d_wb_vld), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
